// File: rtl/trans_seq_monitor.sv
// Per-channel checker for trans -> start_trans -> beats -> end_trans; pulses registered 1 cycle after the deciding sample, never stalls.
// Define TRANS_SEQ_MON_ERRINFO_EN to add the sticky err_code/err_step outputs.
module trans_seq_monitor #(
    parameter int NCH         = 4,
    parameter int PAYLOAD_LEN = 3,
    parameter int MAX_GAP     = 0,
    parameter int CNT_W       = 16,
    localparam int SEL_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                       sysclk,
    input  logic                       rst_n,
    input  logic [NCH-1:0]             trans,
    input  logic [NCH-1:0]             start_trans,
    input  logic [NCH*PAYLOAD_LEN-1:0] beat,
    input  logic [NCH-1:0]             end_trans,
    input  logic                       clr_cnt,
    input  logic [SEL_W-1:0]           cnt_sel,
    output logic [NCH-1:0]             busy,
    output logic [NCH-1:0]             match_pulse,
    output logic [NCH-1:0]             fail_pulse,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [CNT_W-1:0]           fail_cnt
`ifdef TRANS_SEQ_MON_ERRINFO_EN
    ,
    output logic [2*NCH-1:0]           err_code,
    output logic [4*NCH-1:0]           err_step
`endif
);

    localparam int IDX_W = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam int GAP_W = $clog2(MAX_GAP + 2);
    localparam logic [SEL_W:0] NCH_L = NCH[SEL_W:0];
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);

    typedef enum logic [1:0] {IDLE, WAIT_START, PAYLOAD, WAIT_END} state_t;

    state_t                 state   [NCH];
    logic [IDX_W-1:0]       idx     [NCH];
    logic [GAP_W-1:0]       gap     [NCH];
    logic [CNT_W-1:0]       m_cnt   [NCH];
    logic [CNT_W-1:0]       f_cnt   [NCH];
    logic [PAYLOAD_LEN-1:0] ch_beat [NCH];
    logic [NCH-1:0]         hit;
    logic [NCH-1:0]         ooo;
    logic [NCH-1:0]         fail;
    logic [NCH-1:0]         done;
`ifdef TRANS_SEQ_MON_ERRINFO_EN
    logic [3:0]             step_num [NCH];
`endif

    for (genvar g = 0; g < NCH; g++) begin : g_beat
        assign ch_beat[g] = beat[g*PAYLOAD_LEN +: PAYLOAD_LEN];
    end

    // hit: the one expected strobe; ooo: any other step strobe of the channel (trans excluded)
    always_comb begin
        hit  = '0;
        ooo  = '0;
        fail = '0;
        done = '0;
        for (int c = 0; c < NCH; c++) begin
            case (state[c])
                WAIT_START: begin
                    hit[c] = start_trans[c];
                    ooo[c] = end_trans[c] | (|ch_beat[c]);
                end
                PAYLOAD: begin
                    hit[c] = ch_beat[c][idx[c]];
                    ooo[c] = start_trans[c] | end_trans[c]
                           | (|(ch_beat[c] & ~(PAYLOAD_LEN'(1) << idx[c])));
                end
                WAIT_END: begin
                    hit[c] = end_trans[c];
                    ooo[c] = start_trans[c] | (|ch_beat[c]);
                end
                default: ;
            endcase
            fail[c] = (state[c] != IDLE) && (ooo[c] || (!hit[c] && gap[c] == GAP_W'(MAX_GAP)));
            done[c] = (state[c] == WAIT_END) && hit[c] && !ooo[c];
        end
    end

`ifdef TRANS_SEQ_MON_ERRINFO_EN
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            step_num[c] = 4'd0;
            case (state[c])
                WAIT_START: step_num[c] = 4'd1;
                PAYLOAD:    step_num[c] = 4'(idx[c]) + 4'd2;
                WAIT_END:   step_num[c] = 4'(PAYLOAD_LEN + 2);
                default:    ;
            endcase
        end
    end
`endif

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            busy        <= '0;
            match_pulse <= '0;
            fail_pulse  <= '0;
            for (int c = 0; c < NCH; c++) begin
                state[c] <= IDLE;
                idx[c]   <= '0;
                gap[c]   <= '0;
                m_cnt[c] <= '0;
                f_cnt[c] <= '0;
            end
`ifdef TRANS_SEQ_MON_ERRINFO_EN
            err_code <= '0;
            err_step <= '0;
`endif
        end else begin
            match_pulse <= done;
            fail_pulse  <= fail;
            for (int c = 0; c < NCH; c++) begin
                if (clr_cnt) begin
                    m_cnt[c] <= '0;
                    f_cnt[c] <= '0;
                end else begin
                    if (done[c] && m_cnt[c] != '1) m_cnt[c] <= m_cnt[c] + 1'b1;
                    if (fail[c] && f_cnt[c] != '1) f_cnt[c] <= f_cnt[c] + 1'b1;
                end
`ifdef TRANS_SEQ_MON_ERRINFO_EN
                // first failure sticks until cleared
                if (clr_cnt) begin
                    err_code[2*c +: 2] <= 2'b00;
                    err_step[4*c +: 4] <= 4'd0;
                end else if (fail[c] && err_code[2*c +: 2] == 2'b00) begin
                    err_code[2*c +: 2] <= ooo[c] ? 2'b10 : 2'b01;
                    err_step[4*c +: 4] <= step_num[c];
                end
`endif
                if (state[c] == IDLE) begin
                    busy[c] <= trans[c];
                    gap[c]  <= '0;
                    idx[c]  <= '0;
                    if (trans[c]) state[c] <= WAIT_START;
                end else if (fail[c]) begin
                    busy[c]  <= 1'b0;
                    state[c] <= IDLE;
                end else if (hit[c]) begin
                    busy[c] <= 1'b1;
                    gap[c]  <= '0;
                    case (state[c])
                        WAIT_START: begin
                            state[c] <= PAYLOAD;
                            idx[c]   <= '0;
                        end
                        PAYLOAD: begin
                            if (idx[c] == LAST_IDX) state[c] <= WAIT_END;
                            else idx[c] <= idx[c] + 1'b1;
                        end
                        default: begin
                            state[c] <= IDLE;
                            busy[c]  <= 1'b0;
                        end
                    endcase
                end else begin
                    busy[c] <= 1'b1;
                    gap[c]  <= gap[c] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        match_cnt = '0;
        fail_cnt  = '0;
        if ({1'b0, cnt_sel} < NCH_L) begin
            match_cnt = m_cnt[cnt_sel];
            fail_cnt  = f_cnt[cnt_sel];
        end
    end

endmodule

// File: tb/tb_trans_seq_monitor.sv
// Random-stimulus bench: two monitors (strict gap / 16-bit counters, gap 2 / 4-bit counters) against a timestamp model.
module tb_trans_seq_monitor;

    localparam int NCH = 4;
    localparam int PL  = 3;
    localparam int NS  = PL + 2;
    localparam int NCYC = 8000;

    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic                rst_n;
    logic                clr_cnt;
    logic [NCH-1:0]      trans_s [2];
    logic [NCH-1:0]      start_s [2];
    logic [NCH-1:0]      end_s   [2];
    logic [NCH*PL-1:0]   beat_s  [2];
    logic [1:0]          sel_s   [2];
    logic [NCH-1:0]      busy_s  [2];
    logic [NCH-1:0]      mp_s    [2];
    logic [NCH-1:0]      fp_s    [2];
    logic [15:0]         mc0, fc0;
    logic [3:0]          mc1, fc1;
`ifdef TRANS_SEQ_MON_ERRINFO_EN
    logic [2*NCH-1:0]    ec_s [2];
    logic [4*NCH-1:0]    es_s [2];
`endif

    trans_seq_monitor #(.NCH(NCH), .PAYLOAD_LEN(PL), .MAX_GAP(0), .CNT_W(16)) dut0 (
        .sysclk(sysclk), .rst_n(rst_n), .trans(trans_s[0]), .start_trans(start_s[0]),
        .beat(beat_s[0]), .end_trans(end_s[0]), .clr_cnt(clr_cnt), .cnt_sel(sel_s[0]),
        .busy(busy_s[0]), .match_pulse(mp_s[0]), .fail_pulse(fp_s[0]),
        .match_cnt(mc0), .fail_cnt(fc0)
`ifdef TRANS_SEQ_MON_ERRINFO_EN
        , .err_code(ec_s[0]), .err_step(es_s[0])
`endif
    );

    trans_seq_monitor #(.NCH(NCH), .PAYLOAD_LEN(PL), .MAX_GAP(2), .CNT_W(4)) dut1 (
        .sysclk(sysclk), .rst_n(rst_n), .trans(trans_s[1]), .start_trans(start_s[1]),
        .beat(beat_s[1]), .end_trans(end_s[1]), .clr_cnt(clr_cnt), .cnt_sel(sel_s[1]),
        .busy(busy_s[1]), .match_pulse(mp_s[1]), .fail_pulse(fp_s[1]),
        .match_cnt(mc1), .fail_cnt(fc1)
`ifdef TRANS_SEQ_MON_ERRINFO_EN
        , .err_code(ec_s[1]), .err_step(es_s[1])
`endif
    );

    // Model: next expected step number (0 = idle) and cycle stamp of the last accepted step.
    int nxt   [2][NCH];
    int last  [2][NCH];
    int mcnt  [2][NCH];
    int fcnt  [2][NCH];
    int ecode [2][NCH];
    int estep [2][NCH];
    logic [NCH-1:0] exp_busy [2];
    logic [NCH-1:0] exp_mp   [2];
    logic [NCH-1:0] exp_fp   [2];
    int cyc;
    int n_chk = 0;
    int n_err = 0;

    function automatic int max_gap(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic int sat_val(input int d);
        return (d == 0) ? 65535 : 15;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit asserted(input int d, input int c, input int s);
        if (s == 1)  return start_s[d][c];
        if (s == NS) return end_s[d][c];
        return beat_s[d][c*PL + s - 2];
    endfunction

    task automatic set_step(input int d, input int c, input int s);
        if (s == 1)       start_s[d][c] = 1'b1;
        else if (s == NS) end_s[d][c] = 1'b1;
        else              beat_s[d][c*PL + s - 2] = 1'b1;
    endtask

    task automatic drive(input int d);
        trans_s[d] = '0;
        start_s[d] = '0;
        end_s[d]   = '0;
        beat_s[d]  = '0;
        sel_s[d]   = 2'($urandom_range(0, NCH-1));
        for (int c = 0; c < NCH; c++) begin
            int r;
            int s;
            r = $urandom_range(0, 31);
            if (nxt[d][c] == 0) begin
                trans_s[d][c] = 1'($urandom_range(0, 1));
                if (r < 4) set_step(d, c, $urandom_range(1, NS));
            end else begin
                trans_s[d][c] = ($urandom_range(0, 3) == 0);
                if (r == 31) begin
                    s = $urandom_range(1, NS);
                    if (s == nxt[d][c]) s = (s % NS) + 1;
                    set_step(d, c, s);
                    if ($urandom_range(0, 1) == 1) set_step(d, c, nxt[d][c]);
                end else if (r >= ((d == 0) ? 1 : 6)) begin
                    set_step(d, c, nxt[d][c]);
                end
            end
        end
    endtask

    task automatic model_cycle(input int d);
        exp_mp[d] = '0;
        exp_fp[d] = '0;
        for (int c = 0; c < NCH; c++) begin
            bit seen;
            bit other;
            bit failed;
            seen = 0;
            other = 0;
            failed = 0;
            if (!rst_n) begin
                nxt[d][c] = 0;
                mcnt[d][c] = 0;
                fcnt[d][c] = 0;
                ecode[d][c] = 0;
                estep[d][c] = 0;
            end else begin
                if (nxt[d][c] == 0) begin
                    if (trans_s[d][c]) begin
                        nxt[d][c] = 1;
                        last[d][c] = cyc;
                    end
                end else begin
                    for (int s = 1; s <= NS; s++)
                        if (asserted(d, c, s)) begin
                            if (s == nxt[d][c]) seen = 1;
                            else other = 1;
                        end
                    if (other || (!seen && cyc - last[d][c] > max_gap(d))) begin
                        failed = 1;
                        exp_fp[d][c] = 1'b1;
                        if (ecode[d][c] == 0) begin
                            ecode[d][c] = other ? 2 : 1;
                            estep[d][c] = nxt[d][c];
                        end
                        nxt[d][c] = 0;
                        if (fcnt[d][c] < sat_val(d)) fcnt[d][c]++;
                    end else if (seen) begin
                        last[d][c] = cyc;
                        if (nxt[d][c] == NS) begin
                            nxt[d][c] = 0;
                            exp_mp[d][c] = 1'b1;
                            if (mcnt[d][c] < sat_val(d)) mcnt[d][c]++;
                        end else begin
                            nxt[d][c]++;
                        end
                    end
                end
                if (clr_cnt) begin
                    mcnt[d][c] = 0;
                    fcnt[d][c] = 0;
                    ecode[d][c] = 0;
                    estep[d][c] = 0;
                end
            end
            exp_busy[d][c] = (nxt[d][c] != 0);
        end
    endtask

    initial begin
        logic [31:0] mc;
        logic [31:0] fc;
        cyc = 0;
        rst_n = 1'b0;
        clr_cnt = 1'b0;
        for (int d = 0; d < 2; d++) begin
            trans_s[d] = '0; start_s[d] = '0; end_s[d] = '0; beat_s[d] = '0; sel_s[d] = '0;
        end
        for (int i = 0; i < NCYC; i++) begin
            @(negedge sysclk);
            if (i > 0) begin
                for (int d = 0; d < 2; d++) begin
                    mc = (d == 0) ? {16'd0, mc0} : {28'd0, mc1};
                    fc = (d == 0) ? {16'd0, fc0} : {28'd0, fc1};
                    check($sformatf("busy%0d", d), {28'd0, busy_s[d]}, {28'd0, exp_busy[d]});
                    check($sformatf("match_pulse%0d", d), {28'd0, mp_s[d]}, {28'd0, exp_mp[d]});
                    check($sformatf("fail_pulse%0d", d), {28'd0, fp_s[d]}, {28'd0, exp_fp[d]});
                    check($sformatf("match_cnt%0d", d), mc, mcnt[d][sel_s[d]]);
                    check($sformatf("fail_cnt%0d", d), fc, fcnt[d][sel_s[d]]);
`ifdef TRANS_SEQ_MON_ERRINFO_EN
                    for (int c = 0; c < NCH; c++) begin
                        check($sformatf("err_code%0d_%0d", d, c), {30'd0, ec_s[d][2*c +: 2]}, ecode[d][c]);
                        check($sformatf("err_step%0d_%0d", d, c), {28'd0, es_s[d][4*c +: 4]}, estep[d][c]);
                    end
`endif
                end
            end
            rst_n   = (i < 2) ? 1'b0 : ($urandom_range(0, 1499) != 0);
            clr_cnt = ($urandom_range(0, 999) == 0);
            for (int d = 0; d < 2; d++) begin
                drive(d);
                model_cycle(d);
            end
            cyc++;
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
